// File: rtl/revaluate_controller.sv
// revaluate_controller: batch sequencer driving the Keccak-f[1600] round datapath, file reader and writer.
// Outputs are registered from the next state, so every strobe lines up with the state it belongs to.
module revaluate_controller #(
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = 5,
  parameter int IDX_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   num_files,
  input  logic               read_valid,
  output logic               read_file,
  output logic               load_state,
  output logic               round_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               write_file,
  output logic [IDX_W-1:0]   file_index,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, LOAD, ROUND, WRITE, DONE} state_t;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  state_t             r_state, w_next;
  logic [IDX_W-1:0]   r_num, w_num, w_idx;
  logic [ROUND_W-1:0] w_round;
  always_comb begin
    w_next = r_state;
    w_num  = r_num;
    w_idx  = file_index;
    case (r_state)
      IDLE: if (start) begin
        w_num  = num_files;
        w_idx  = '0;
        w_next = (num_files == '0) ? DONE : READ_REQ;
      end
      READ_REQ:  w_next = READ_WAIT;
      READ_WAIT: w_next = read_valid ? LOAD : READ_WAIT;
      LOAD:      w_next = ROUND;
      ROUND:     w_next = (round_idx == LAST_ROUND) ? WRITE : ROUND;
      WRITE: if (file_index == r_num - IDX_W'(1)) w_next = DONE;
        else begin
          w_idx  = file_index + IDX_W'(1);
          w_next = READ_REQ;
        end
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    // round counter only advances while staying in ROUND; it enters ROUND from LOAD at 0
    w_round = (r_state == ROUND && w_next == ROUND) ? round_idx + ROUND_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_num      <= '0;
      file_index <= '0;
      read_file  <= 1'b0;
      load_state <= 1'b0;
      round_en   <= 1'b0;
      round_idx  <= '0;
      write_file <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_num      <= w_num;
      file_index <= w_idx;
      read_file  <= w_next == READ_REQ;
      load_state <= w_next == LOAD;
      round_en   <= w_next == ROUND;
      round_idx  <= w_round;
      write_file <= w_next == WRITE;
      busy       <= w_next != IDLE;
      done       <= w_next == DONE;
    end
  end
endmodule
